// File: rtl/vedic_mul_pipe_pkg.sv
// vedic_mul_pipe_pkg: shared stage-count constants and latency helpers
package vedic_mul_pipe_pkg;
    localparam int FRONT_STAGES = 1;
    localparam int OUT_STAGES = 1;
    localparam int LEVEL_STAGES = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int vedic_lat(input int w);
        return LEVEL_STAGES * clog2(w);
    endfunction

    function automatic int core_lat(input int w);
        return vedic_lat(w) - FRONT_STAGES - OUT_STAGES;
    endfunction
endpackage

// File: rtl/vedic_mul_pipe_if.sv
// vedic_mul_pipe_if: operand/result valid-ready bus of the multiplier
interface vedic_mul_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic signed_mode;
    logic [TAG_W-1:0] tag_in;
    logic out_valid;
    logic out_ready;
    logic [2*WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, a, b, signed_mode, tag_in, out_ready,
        input in_ready, out_valid, result, tag_out
    );

    modport slave (
        input in_valid, a, b, signed_mode, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out
    );
endinterface

// File: rtl/vedic_mul_pipe_core.sv
// vedic_core: recursive unsigned Urdhva-Tiryakbhyam multiplier, 3 stages per doubling over a 1-stage 2x2 leaf
module vedic_core
    import vedic_mul_pipe_pkg::*;
#(
    parameter int N = 8
) (
    input logic clk,
    input logic reset,
    input logic en_i,
    input logic v_i,
    input logic [N-1:0] x_i,
    input logic [N-1:0] y_i,
    output logic v_o,
    output logic [2*N-1:0] p_o,
    output logic busy_o
);
    if (N == 2) begin : g_leaf
        logic v_q;
        logic [3:0] p_q;
        // leaf valid bit
        always_ff @(posedge clk) begin
            if (reset) v_q <= 1'b0;
            else if (en_i) v_q <= v_i;
        end
        // 2x2 product
        always_ff @(posedge clk) begin
            if (en_i) p_q <= {2'b00, x_i} * {2'b00, y_i};
        end
        assign v_o = v_q;
        assign p_o = p_q;
        assign busy_o = v_q;
    end else begin : g_node
        localparam int H = N / 2;
        logic [N-1:0] hh, hl, lh, ll;
        logic [3:0] sv, sb;
        logic [LEVEL_STAGES-1:0] v_q;
        logic [N:0] cross_q, mid_q;
        logic [N-1:0] hh1_q, ll1_q, hh2_q, hi_q, lo_q;
        logic [H-1:0] ll2_q;

        vedic_core #(.N(H)) u_hh (.clk(clk), .reset(reset), .en_i(en_i), .v_i(v_i), .x_i(x_i[N-1:H]), .y_i(y_i[N-1:H]), .v_o(sv[3]), .p_o(hh), .busy_o(sb[3]));
        vedic_core #(.N(H)) u_hl (.clk(clk), .reset(reset), .en_i(en_i), .v_i(v_i), .x_i(x_i[N-1:H]), .y_i(y_i[H-1:0]), .v_o(sv[2]), .p_o(hl), .busy_o(sb[2]));
        vedic_core #(.N(H)) u_lh (.clk(clk), .reset(reset), .en_i(en_i), .v_i(v_i), .x_i(x_i[H-1:0]), .y_i(y_i[N-1:H]), .v_o(sv[1]), .p_o(lh), .busy_o(sb[1]));
        vedic_core #(.N(H)) u_ll (.clk(clk), .reset(reset), .en_i(en_i), .v_i(v_i), .x_i(x_i[H-1:0]), .y_i(y_i[H-1:0]), .v_o(sv[0]), .p_o(ll), .busy_o(sb[0]));

        // valid shift through the three combine stages; the four sub-cores run in lockstep
        always_ff @(posedge clk) begin
            if (reset) v_q <= '0;
            else if (en_i) v_q <= {v_q[LEVEL_STAGES-2:0], &sv};
        end
        // cross sum, middle fold, then high add; the top carry is provably zero so hi stays N bits
        always_ff @(posedge clk) begin
            if (en_i) begin
                cross_q <= {1'b0, hl} + {1'b0, lh};
                hh1_q <= hh;
                ll1_q <= ll;
                mid_q <= cross_q + {{(H+1){1'b0}}, ll1_q[N-1:H]};
                hh2_q <= hh1_q;
                ll2_q <= ll1_q[H-1:0];
                hi_q <= hh2_q + {{(H-1){1'b0}}, mid_q[N:H]};
                lo_q <= {mid_q[H-1:0], ll2_q};
            end
        end
        assign v_o = v_q[LEVEL_STAGES-1];
        assign p_o = {hi_q, lo_q};
        assign busy_o = |{sb, v_q};
    end
endmodule

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: pipelined signed/unsigned Vedic multiplier with tag sideband and valid/ready flow control
module vedic_mul_pipe
    import vedic_mul_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic reset,
    vedic_mul_pipe_if.slave bus,
    output logic busy
);
    localparam int CL = core_lat(WIDTH);

    logic adv;
    logic [WIDTH-1:0] mag_a_d, mag_b_d, mag_a_q, mag_b_q;
    logic neg_d, v0_q, core_v, core_busy;
    logic [CL:0] neg_q;
    logic [TAG_W-1:0] tag_q [CL+1];
    logic [2*WIDTH-1:0] core_p;

    assign adv = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign busy = v0_q | core_busy | bus.out_valid;

    // sign-magnitude split; the most negative value maps to 2^(WIDTH-1), which fits unsigned
    always_comb begin
        mag_a_d = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b_d = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_d = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end

    // input stage valid bit
    always_ff @(posedge clk) begin
        if (reset) v0_q <= 1'b0;
        else if (adv) v0_q <= bus.in_valid;
    end

    // operand magnitudes plus neg/tag delay lines matched to the core depth
    always_ff @(posedge clk) begin
        if (adv) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q <= {neg_q[CL-1:0], neg_d};
            tag_q[0] <= bus.tag_in;
            for (int i = 1; i <= CL; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    vedic_core #(.N(WIDTH)) u_core (
        .clk(clk),
        .reset(reset),
        .en_i(adv),
        .v_i(v0_q),
        .x_i(mag_a_q),
        .y_i(mag_b_q),
        .v_o(core_v),
        .p_o(core_p),
        .busy_o(core_busy)
    );

    // sign restore and output register; result/tag hold their last value between operations
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.result <= '0;
            bus.tag_out <= '0;
        end else if (adv) begin
            bus.out_valid <= core_v;
            if (core_v) begin
                bus.result <= neg_q[CL] ? -core_p : core_p;
                bus.tag_out <= tag_q[CL];
            end
        end
    end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb_vedic_mul_pipe: table, directed and random checks of vedic_mul_pipe at WIDTH 8, 16 and 4
module tb_vedic_mul_pipe;
    localparam int W = 8;
    localparam int TW = 4;
    localparam int LAT = 9;
    localparam int NREG = 10000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit sm;
        logic [15:0] res;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [TW-1:0] tag;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_lat = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vedic_mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy));

    function automatic longint ref_mul(input int w, input longint a, input longint b, input bit sm);
        longint x, y;
        x = (sm && a[w-1]) ? a - (longint'(1) << w) : a;
        y = (sm && b[w-1]) ? b - (longint'(1) << w) : b;
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic check(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic step(input bit rst, input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                        input bit ism, input logic [TW-1:0] itg, input bit ordy,
                        input logic [15:0] ex, output bit acc);
        @(negedge clk);
        reset = rst;
        bus.in_valid = iv;
        bus.a = ia;
        bus.b = ib;
        bus.signed_mode = ism;
        bus.tag_in = itg;
        bus.out_ready = ordy;
        #1;
        cyc++;
        acc = 1'b0;
        if (rst) sb.delete();
        else begin
            if (bus.out_valid) begin
                if (sb.size() == 0) check("spurious out_valid", bus.out_valid, 0);
                else begin
                    check("result", bus.result, sb[0].res);
                    check("tag_out", bus.tag_out, sb[0].tag);
                    if (ordy) begin
                        if (chk_lat) check("latency", cyc - sb[0].cyc, LAT);
                        void'(sb.pop_front());
                    end
                end
            end
            acc = iv && bus.in_ready;
            if (acc) sb.push_back('{ex, itg, cyc});
        end
    endtask

    task automatic drain(input string name);
        bit acc;
        for (int i = 0; i < 60 && sb.size() != 0; i++) step(0, 0, 0, 0, 0, 0, 1, 0, acc);
        check(name, sb.size(), 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, acc);
        check("busy after drain", busy, 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_reg
        localparam int RW = g ? 16 : 4;
        localparam int RL = g ? 12 : 6;
        logic rr;
        logic rbusy;
        bit fin = 1'b0;
        logic [2*RW-1:0] eq[$];
        logic [TW-1:0] tq[$];
        vedic_mul_pipe_if #(.WIDTH(RW), .TAG_W(TW)) rbus ();
        vedic_mul_pipe #(.WIDTH(RW), .TAG_W(TW)) rdut (.clk(clk), .reset(rr), .bus(rbus), .busy(rbusy));

        initial begin
            int sent, got, rc, lat;
            bit pend;
            logic [RW-1:0] ra, rb;
            bit rsm;
            logic [TW-1:0] rt;
            rr = 1'b1;
            rbus.in_valid = 1'b0;
            rbus.a = '0;
            rbus.b = '0;
            rbus.signed_mode = 1'b0;
            rbus.tag_in = '0;
            rbus.out_ready = 1'b1;
            repeat (3) @(negedge clk);
            rr = 1'b0;
            rbus.in_valid = 1'b1;
            rbus.a = '1;
            rbus.b = '1;
            #1;
            check("reg probe in_ready", rbus.in_ready, 1);
            lat = 0;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                @(negedge clk);
                rbus.in_valid = 1'b0;
                #1;
                if (rbus.out_valid) lat = k;
            end
            check("reg latency", lat, RL);
            check("reg probe result", rbus.result, ref_mul(RW, (longint'(1) << RW) - 1, (longint'(1) << RW) - 1, 0));
            sent = 0;
            got = 0;
            rc = 0;
            pend = 1'b0;
            while (got < NREG && rc < 60000) begin
                @(negedge clk);
                rc++;
                if (!pend) begin
                    ra = RW'($urandom);
                    rb = RW'($urandom);
                    rsm = 1'($urandom);
                    rt = TW'($urandom);
                end
                rbus.in_valid = (sent < NREG) && ($urandom_range(0, 9) != 0);
                rbus.a = ra;
                rbus.b = rb;
                rbus.signed_mode = rsm;
                rbus.tag_in = rt;
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (rbus.out_valid) begin
                    if (eq.size() == 0) check("reg spurious out_valid", rbus.out_valid, 0);
                    else begin
                        check("reg result", rbus.result, eq[0]);
                        check("reg tag_out", rbus.tag_out, tq[0]);
                        if (rbus.out_ready) begin
                            void'(eq.pop_front());
                            void'(tq.pop_front());
                            got++;
                        end
                    end
                end
                pend = !(rbus.in_valid && rbus.in_ready);
                if (!pend) begin
                    eq.push_back((2*RW)'(ref_mul(RW, ra, rb, rsm)));
                    tq.push_back(rt);
                    sent++;
                end
            end
            check("reg ops consumed", got, NREG);
            @(negedge clk);
            rbus.in_valid = 1'b0;
            rbus.out_ready = 1'b1;
            #1;
            check("reg busy idle", rbusy, 0);
            fin = 1'b1;
        end
    end

    initial begin
        vec_t vt[12];
        bit acc, pend;
        logic [7:0] ra, rb;
        bit rsm;
        vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vt[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vt[3] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vt[4] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
        vt[5] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vt[6] = '{8'h80, 8'h02, 1'b1, 16'hFF00};
        vt[7] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vt[8] = '{8'h00, 8'h00, 1'b0, 16'h0000};
        vt[9] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vt[10] = '{8'h03, 8'hFD, 1'b1, 16'hFFF7};
        vt[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        bus.tag_in = '0;
        bus.out_ready = 1'b1;
        repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 0, acc);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset result", bus.result, 0);
        check("reset tag_out", bus.tag_out, 0);
        check("reset in_ready", bus.in_ready, 1);

        chk_lat = 1'b1;
        step(0, 1, 8'hFF, 8'hFF, 0, 4'd3, 1, 16'hFE01, acc);
        check("single op accepted", acc, 1);
        drain("single op drain");

        for (int i = 0; i < 12; i++) begin
            step(0, 1, vt[i].a, vt[i].b, vt[i].sm, i[3:0], 1, vt[i].res, acc);
            check("table in_ready", bus.in_ready, 1);
        end
        drain("table drain");

        chk_lat = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (!pend) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rsm = 1'($urandom);
            end
            step(0, 1, ra, rb, rsm, i[3:0], !(i >= 12 && i < 17), 16'(ref_mul(8, ra, rb, rsm)), acc);
            check("stall in_ready", bus.in_ready, !(i >= 12 && i < 17));
            pend = !acc;
        end
        drain("backpressure drain");

        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            step(0, 1, ra, rb, 1, i[3:0], 1, 16'(ref_mul(8, ra, rb, 1)), acc);
        end
        step(1, 0, 0, 0, 0, 0, 1, 0, acc);
        step(0, 0, 0, 0, 0, 0, 1, 0, acc);
        check("post-reset busy", busy, 0);
        check("post-reset in_ready", bus.in_ready, 1);
        check("post-reset out_valid", bus.out_valid, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0, acc);
            check("no ghost out_valid", bus.out_valid, 0);
        end
        chk_lat = 1'b1;
        step(0, 1, 8'hF6, 8'h07, 1, 4'd9, 1, 16'(ref_mul(8, 8'hF6, 8'h07, 1)), acc);
        check("post-reset op accepted", acc, 1);
        drain("post-reset drain");

        for (int i = 0; i < 8; i++) step(0, 1, 8'h80, 8'h02, i[0], i[3:0], 1, i[0] ? 16'hFF00 : 16'h0100, acc);
        drain("alternating mode drain");

        chk_lat = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rsm = 1'($urandom);
            end
            step(0, $urandom_range(0, 3) != 0, ra, rb, rsm, i[3:0], $urandom_range(0, 9) > 2, 16'(ref_mul(8, ra, rb, rsm)), acc);
            pend = !acc;
        end
        drain("random drain");

        for (int i = 0; i < 70000 && !(g_reg[0].fin && g_reg[1].fin); i++) @(negedge clk);
        check("regressions finished", {g_reg[1].fin, g_reg[0].fin}, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
